// File: rtl/data_mem_resp.sv
// Data-memory responder: word-addressed RAM plus a memory-mapped timer with a level IRQ.
// Optional macro TIMER_PRESCALE_EN adds an 8-bit prescaler register at MMIO index 4.

module data_mem_resp #(
  parameter int         RAM_AW    = 12,
  parameter logic [3:0] MMIO_BASE = 4'h1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        timer_irq_o
);

  localparam int DEPTH = 1 << RAM_AW;

  logic [31:0]       mem [DEPTH];
  logic              mmio;
  logic              ram_we;
  logic              mmio_we;
  logic [RAM_AW-1:0] ram_idx;
  logic [2:0]        reg_sel;
  logic              wr_cnt;
  logic              wr_cmp;
  logic              wr_ctrl;
  logic              wr_stat;
  logic [31:0]       cnt;
  logic [31:0]       cmp;
  logic [2:0]        ctrl;
  logic              pend;
  logic              irq;
  logic              tick;
  logic              match;
  logic [31:0]       rd_data;
  logic              unused_addr;

  assign mmio        = (addr_i[31:28] == MMIO_BASE);
  assign ram_idx     = addr_i[RAM_AW+1:2];
  assign reg_sel     = addr_i[4:2];
  assign ram_we      = ce_i & we_i & ~mmio;
  assign mmio_we     = ce_i & we_i & mmio;
  assign wr_cnt      = mmio_we & (reg_sel == 3'd0);
  assign wr_cmp      = mmio_we & (reg_sel == 3'd1);
  assign wr_ctrl     = mmio_we & (reg_sel == 3'd2);
  assign wr_stat     = mmio_we & (reg_sel == 3'd3);
  assign match       = tick & (cnt == cmp);
  assign unused_addr = ^{addr_i[27:RAM_AW+2], addr_i[1:0]};

  // RAM byte-lane writes; contents survive reset but a write landing during reset is dropped.
  always_ff @(posedge clk) begin
    if (!rst && ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (sel_i[b]) begin
          mem[ram_idx][8*b +: 8] <= data_i[8*b +: 8];
        end
      end
    end
  end

`ifdef TIMER_PRESCALE_EN
  logic [7:0] pre;
  logic [7:0] pre_cnt;
  logic       wr_pre;

  assign wr_pre = mmio_we & (reg_sel == 3'd4);
  assign tick   = ctrl[0] & (pre_cnt == pre);

  // Prescale counter runs 0..PRE while enabled; the tick fires on the PRE count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre     <= 8'd0;
      pre_cnt <= 8'd0;
    end else if (wr_pre) begin
      pre     <= data_i[7:0];
      pre_cnt <= 8'd0;
    end else if (!ctrl[0] || tick) begin
      pre_cnt <= 8'd0;
    end else begin
      pre_cnt <= pre_cnt + 8'd1;
    end
  end
`else
  assign tick = ctrl[0];
`endif

  // Timer registers: a CPU write to CNT beats both the increment and the match.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= 32'd0;
      cmp  <= 32'hFFFF_FFFF;
      ctrl <= 3'd0;
      pend <= 1'b0;
      irq  <= 1'b0;
    end else begin
      irq <= pend & ctrl[1];
      if (wr_cmp) begin
        cmp <= data_i;
      end
      if (wr_ctrl) begin
        ctrl <= data_i[2:0];
      end
      if (wr_cnt) begin
        cnt <= data_i;
      end else if (tick) begin
        cnt <= (match && ctrl[2]) ? 32'd0 : cnt + 32'd1;
      end
      if (match && !wr_cnt) begin
        pend <= 1'b1;
      end else if (wr_stat && data_i[0]) begin
        pend <= 1'b0;
      end
    end
  end

  // Same-cycle read path; zero when idle, writing or in reset.
  always_comb begin
    rd_data = 32'd0;
    if (rst || !ce_i || we_i) begin
      rd_data = 32'd0;
    end else if (mmio) begin
      case (reg_sel)
        3'd0:    rd_data = cnt;
        3'd1:    rd_data = cmp;
        3'd2:    rd_data = {29'd0, ctrl};
        3'd3:    rd_data = {31'd0, pend};
`ifdef TIMER_PRESCALE_EN
        3'd4:    rd_data = {24'd0, pre};
`endif
        default: rd_data = 32'd0;
      endcase
    end else begin
      rd_data = mem[ram_idx];
    end
  end

  assign data_o      = rd_data;
  assign timer_irq_o = irq;

endmodule

// File: tb/tb_data_mem_resp.sv
// Self-checking bench for data_mem_resp: vector table, directed timer sequences,
// and randomized traffic against a cycle-level behavioural model.

module tb_data_mem_resp;

  localparam logic [31:0] CNT_A  = 32'h1000_0000;
  localparam logic [31:0] CMP_A  = 32'h1000_0004;
  localparam logic [31:0] CTRL_A = 32'h1000_0008;
  localparam logic [31:0] STAT_A = 32'h1000_000C;
  localparam logic [31:0] PRE_A  = 32'h1000_0010;

  typedef struct {
    logic        ce;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        ce_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [3:0]  sel_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        timer_irq_o;

  int checks = 0;
  int errors = 0;

  // behavioural model state
  logic [31:0] mm [4096];
  bit   [3:0]  kb [4096];
  logic [31:0] m_cnt, m_cmp;
  logic [2:0]  m_ctrl;
  logic        m_pend, m_irq;
  logic [7:0]  m_pre, m_phase;

  data_mem_resp #(.RAM_AW(12), .MMIO_BASE(4'h1)) dut (
    .clk(clk), .rst(rst), .ce_i(ce_i), .we_i(we_i), .addr_i(addr_i),
    .sel_i(sel_i), .data_i(data_i), .data_o(data_o), .timer_irq_o(timer_irq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 32'd0; m_cmp = 32'hFFFF_FFFF; m_ctrl = 3'd0;
    m_pend = 1'b0; m_irq = 1'b0; m_pre = 8'd0; m_phase = 8'd0;
  endtask

  task automatic mread(input logic c, input logic w, input logic [31:0] a,
                       output logic [31:0] v, output bit ok);
    int i;
    ok = 1'b1;
    v  = 32'd0;
    if (c && !w) begin
      if (a[31:28] == 4'h1) begin
        case (a[4:2])
          3'd0: v = m_cnt;
          3'd1: v = m_cmp;
          3'd2: v = {29'd0, m_ctrl};
          3'd3: v = {31'd0, m_pend};
`ifdef TIMER_PRESCALE_EN
          3'd4: v = {24'd0, m_pre};
`endif
          default: v = 32'd0;
        endcase
      end else begin
        i  = int'(a[13:2]);
        v  = mm[i];
        ok = (kb[i] == 4'hF);
      end
    end
  endtask

  // One clock of the specified behaviour, from the register values before the edge.
  task automatic madv(input logic c, input logic w, input logic [31:0] a,
                      input logic [3:0] s, input logic [31:0] d);
    bit          is_mmio, wr, tk, hit;
    int          i;
    logic [31:0] ncnt;
    logic        npend;
    logic [7:0]  nphase;
    is_mmio = (a[31:28] == 4'h1);
    wr      = c && w;
    m_irq   = m_pend & m_ctrl[1];
    if (wr && !is_mmio) begin
      i = int'(a[13:2]);
      for (int b = 0; b < 4; b++) begin
        if (s[b]) begin
          mm[i][8*b +: 8] = d[8*b +: 8];
          kb[i][b] = 1'b1;
        end
      end
    end
`ifdef TIMER_PRESCALE_EN
    tk = m_ctrl[0] && (m_phase == m_pre);
    nphase = (m_ctrl[0] && !tk) ? m_phase + 8'd1 : 8'd0;
`else
    tk = m_ctrl[0];
    nphase = 8'd0;
`endif
    hit   = tk && (m_cnt == m_cmp);
    ncnt  = tk ? ((hit && m_ctrl[2]) ? 32'd0 : m_cnt + 32'd1) : m_cnt;
    npend = hit ? 1'b1 : m_pend;
    if (wr && is_mmio) begin
      case (a[4:2])
        3'd0: begin ncnt = d; npend = m_pend; end
        3'd1: m_cmp = d;
        3'd2: m_ctrl = d[2:0];
        3'd3: if (d[0] && !hit) npend = 1'b0;
`ifdef TIMER_PRESCALE_EN
        3'd4: begin m_pre = d[7:0]; nphase = 8'd0; end
`endif
        default: ;
      endcase
    end
    m_cnt = ncnt; m_pend = npend; m_phase = nphase;
  endtask

  // Called at posedge+1; drives, samples at the falling edge, returns at next posedge+1.
  task automatic step(input logic c, input logic w, input logic [31:0] a, input logic [3:0] s,
                      input logic [31:0] d, output logic [31:0] seen, output logic irq_seen);
    logic [31:0] ev;
    bit          ok;
    ce_i = c; we_i = w; addr_i = a; sel_i = s; data_i = d;
    #4;
    seen = data_o;
    irq_seen = timer_irq_o;
    mread(c, w, a, ev, ok);
    if (ok) chk("model_rd", seen, ev);
    chk("model_irq", {31'd0, irq_seen}, {31'd0, m_irq});
    madv(c, w, a, s, d);
    @(posedge clk);
    #1;
  endtask

  task automatic xstep(input string nm, input logic c, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] ed, input logic ei);
    logic [31:0] seen;
    logic        irq_seen;
    step(c, w, a, 4'hF, d, seen, irq_seen);
    chk(nm, seen, ed);
    chk({nm, "_irq"}, {31'd0, irq_seen}, {31'd0, ei});
  endtask

  // Async reset pulse mid-cycle, with a RAM write held across the edge that must be dropped.
  task automatic do_reset();
    ce_i = 1'b1; we_i = 1'b0; addr_i = CNT_A; sel_i = 4'hF; data_i = 32'd0;
    #2 rst = 1'b1;
    #1;
    chk("rst_data", data_o, 32'd0);
    chk("rst_irq", {31'd0, timer_irq_o}, 32'd0);
    we_i = 1'b1; addr_i = 32'h0000_0200; data_i = 32'hBADC_0FFE;
    @(posedge clk);
    #1 ce_i = 1'b0; we_i = 1'b0;
    #1 rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  vec_t        tbl [15];
  logic [31:0] ac_d [7];
  logic        ac_i [7];
  logic        rc, rw, rirq;
  logic [31:0] ra, rd, rseen;
  logic [3:0]  rs;
  int          rr;

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 32'h0000_0100, 4'hF,    32'h1122_3344, 32'd0};
    tbl[1]  = '{1'b1, 1'b1, 32'h0000_0100, 4'b0100, 32'h00AA_0000, 32'd0};
    tbl[2]  = '{1'b1, 1'b0, 32'h0000_0100, 4'h0,    32'd0,         32'h11AA_3344};
    tbl[3]  = '{1'b0, 1'b0, 32'h0000_0100, 4'h0,    32'd0,         32'd0};
    tbl[4]  = '{1'b1, 1'b1, 32'h0000_4000, 4'hF,    32'hDEAD_BEEF, 32'd0};
    tbl[5]  = '{1'b1, 1'b0, 32'h0000_0000, 4'h0,    32'd0,         32'hDEAD_BEEF};
    tbl[6]  = '{1'b1, 1'b0, CMP_A,         4'h0,    32'd0,         32'hFFFF_FFFF};
    tbl[7]  = '{1'b1, 1'b0, CNT_A,         4'h0,    32'd0,         32'd0};
    tbl[8]  = '{1'b1, 1'b1, 32'h1000_0014, 4'hF,    32'h1234_5678, 32'd0};
    tbl[9]  = '{1'b1, 1'b0, 32'h1000_0014, 4'h0,    32'd0,         32'd0};
    tbl[10] = '{1'b1, 1'b0, PRE_A,         4'h0,    32'd0,         32'd0};
    tbl[11] = '{1'b1, 1'b1, 32'h0000_0200, 4'hF,    32'h0BAD_F00D, 32'd0};
    tbl[12] = '{1'b1, 1'b0, 32'h0000_0200, 4'h0,    32'd0,         32'h0BAD_F00D};
    tbl[13] = '{1'b1, 1'b0, STAT_A,        4'h0,    32'd0,         32'd0};
    tbl[14] = '{1'b1, 1'b0, CTRL_A,        4'h0,    32'd0,         32'd0};
    ac_d = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0, 32'd1, 32'd2};
    ac_i = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    rst = 1'b1; ce_i = 1'b0; we_i = 1'b0; addr_i = 32'd0; sel_i = 4'h0; data_i = 32'd0;
    model_reset();
    #12 rst = 1'b0;
    @(posedge clk);
    #1;

    for (int v = 0; v < 15; v++) begin
      step(tbl[v].ce, tbl[v].we, tbl[v].addr, tbl[v].sel, tbl[v].data, rseen, rirq);
      chk($sformatf("vec%0d", v), rseen, tbl[v].exp);
    end

    // timer match with IRQ one cycle after PEND
    do_reset();
    xstep("tm_cmp", 1'b1, 1'b1, CMP_A, 32'd5, 32'd0, 1'b0);
    xstep("tm_ctrl", 1'b1, 1'b1, CTRL_A, 32'd3, 32'd0, 1'b0);
    for (int k = 0; k < 8; k++) xstep("tm_cnt", 1'b1, 1'b0, CNT_A, 32'd0, 32'(k), (k == 7));
    do_reset();
    xstep("rst_cnt", 1'b1, 1'b0, CNT_A, 32'd0, 32'd0, 1'b0);
    xstep("rst_cmp", 1'b1, 1'b0, CMP_A, 32'd0, 32'hFFFF_FFFF, 1'b0);

    // auto-clear and W1C, including W1C colliding with a match
    do_reset();
    xstep("ac_cmp", 1'b1, 1'b1, CMP_A, 32'd3, 32'd0, 1'b0);
    xstep("ac_ctrl", 1'b1, 1'b1, CTRL_A, 32'd7, 32'd0, 1'b0);
    for (int k = 0; k < 7; k++) xstep("ac_cnt", 1'b1, 1'b0, CNT_A, 32'd0, ac_d[k], ac_i[k]);
    xstep("ac_w1c_hit", 1'b1, 1'b1, STAT_A, 32'd1, 32'd0, 1'b1);
    xstep("ac_cnt_a", 1'b1, 1'b0, CNT_A, 32'd0, 32'd0, 1'b1);
    xstep("ac_cnt_b", 1'b1, 1'b0, CNT_A, 32'd0, 32'd1, 1'b1);
    xstep("ac_w1c", 1'b1, 1'b1, STAT_A, 32'd1, 32'd0, 1'b1);
    xstep("ac_cnt_c", 1'b1, 1'b0, CNT_A, 32'd0, 32'd3, 1'b1);
    xstep("ac_stat", 1'b1, 1'b0, STAT_A, 32'd0, 32'd1, 1'b0);
    xstep("ac_cnt_d", 1'b1, 1'b0, CNT_A, 32'd0, 32'd1, 1'b1);

    // CPU write to CNT on the match cycle
    do_reset();
    xstep("co_cmp", 1'b1, 1'b1, CMP_A, 32'd5, 32'd0, 1'b0);
    xstep("co_ctrl", 1'b1, 1'b1, CTRL_A, 32'd3, 32'd0, 1'b0);
    for (int k = 0; k < 5; k++) xstep("co_cnt", 1'b1, 1'b0, CNT_A, 32'd0, 32'(k), 1'b0);
    xstep("co_wr", 1'b1, 1'b1, CNT_A, 32'd100, 32'd0, 1'b0);
    xstep("co_cnt100", 1'b1, 1'b0, CNT_A, 32'd0, 32'd100, 1'b0);
    xstep("co_stat", 1'b1, 1'b0, STAT_A, 32'd0, 32'd0, 1'b0);
    xstep("co_cnt102", 1'b1, 1'b0, CNT_A, 32'd0, 32'd102, 1'b0);

`ifdef TIMER_PRESCALE_EN
    do_reset();
    xstep("ps_pre", 1'b1, 1'b1, PRE_A, 32'd3, 32'd0, 1'b0);
    xstep("ps_ctrl", 1'b1, 1'b1, CTRL_A, 32'd1, 32'd0, 1'b0);
    for (int k = 0; k < 9; k++) xstep("ps_cnt", 1'b1, 1'b0, CNT_A, 32'd0, 32'(k / 4), 1'b0);
    xstep("ps_pre_rd", 1'b1, 1'b0, PRE_A, 32'd0, 32'd3, 1'b0);
    do_reset();
    xstep("ps_rst_cnt", 1'b1, 1'b0, CNT_A, 32'd0, 32'd0, 1'b0);
    xstep("ps_rst_pre", 1'b1, 1'b0, PRE_A, 32'd0, 32'd0, 1'b0);
`else
    xstep("pre_wr", 1'b1, 1'b1, PRE_A, 32'd3, 32'd0, 1'b0);
    xstep("pre_rd", 1'b1, 1'b0, PRE_A, 32'd0, 32'd0, 1'b0);
`endif

    // randomized traffic against the model
    do_reset();
    for (int n = 0; n < 600; n++) begin
      rc = ($urandom_range(0, 9) != 0);
      rw = 1'($urandom_range(0, 1));
      rs = 4'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        rr = int'($urandom_range(0, 7));
        ra = 32'h1000_0000 | (32'($urandom) & 32'h0FFF_FFE0) | (32'(rr) << 2);
        case (rr)
          0, 1:    rd = 32'($urandom_range(0, 12));
          2:       begin rd = 32'($urandom_range(0, 7)); if ($urandom_range(0, 3) != 0) rd[0] = 1'b1; end
          4:       rd = 32'($urandom_range(0, 3));
          default: rd = 32'($urandom);
        endcase
      end else begin
        ra = 32'($urandom) & 32'h0FFF_C03C;
        if ($urandom_range(0, 1) == 1) ra[31:28] = 4'hE;
        rd = 32'($urandom);
      end
      step(rc, rw, ra, rs, rd, rseen, rirq);
    end
    xstep("ram_keep", 1'b1, 1'b0, 32'h0000_0200, 32'd0, 32'h0BAD_F00D, m_irq);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_resp.md
Name: data_mem_resp

Overview:
- Responder end of the core's data-memory port (ram_ce/we/sel/addr/data) and its interrupt input.
- Decodes each access into a word-addressed data RAM or a memory-mapped timer register bank.
- Returns read data in the same cycle.
- Timer raises a level interrupt intended for one bit of the core's int_i.

Parameters:
- RAM_AW, 12, RAM word-address width; depth = 2**RAM_AW words of 32 bits.
- MMIO_BASE, 4'h1, value of addr_i[31:28] that selects the timer bank; any other value selects RAM.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- ce_i  in  1  access strobe from core.
- we_i  in  1  1 = write, 0 = read.
- addr_i  in  32  byte address; addr_i[1:0] ignored (core aligns).
- sel_i  in  4  byte lanes, big-endian: sel_i[3] -> data[31:24] = byte offset 0.
- data_i  in  32  write data.
- data_o  out  32  read data.
- timer_irq_o  out  1  level interrupt, wired to one int_i bit.

Behaviour:
- Decode:
  - mmio = (addr_i[31:28] == MMIO_BASE).
  - RAM index = addr_i[RAM_AW+1:2]; upper bits ignored, so addresses alias/wrap modulo depth.
- RAM:
  - Write on clock edge when ce_i & we_i & !mmio; only lanes with sel_i bit set are updated.
  - Read is combinational: data_o = mem[index] when ce_i & !we_i & !mmio.
  - RAM contents are not cleared by reset.
- data_o:
  - 0 whenever ce_i = 0, during writes, and while rst = 1.
  - sel_i does not mask read data; the core extracts bytes.
- MMIO registers (addr_i[4:2]):
  - 0 CNT, R/W, 32 bit.
  - 1 CMP, R/W, 32 bit.
  - 2 CTRL, R/W: bit0 EN, bit1 IE, bit2 AUTOCLR.
  - 3 STAT, bit0 PEND, write-1-to-clear.
  - 4 PRE (see optional feature).
  - 5-7 read 0, writes ignored.
  - MMIO writes are full-word; sel_i is ignored.
- Reset values: CNT = 0, CMP = 32'hFFFF_FFFF, CTRL = 0, PEND = 0, timer_irq_o = 0, data_o = 0.
- Counter:
  - Each cycle with EN = 1 (and a prescale tick, if enabled): CNT <= CNT + 1, wrapping 32'hFFFF_FFFF -> 0.
  - Match: EN = 1 and CNT == CMP at a tick edge. On a match, PEND <= 1 and, if AUTOCLR, CNT <= 0 instead of incrementing.
- Output: timer_irq_o = PEND & IE, registered (one cycle after PEND changes).
- Simultaneous events:
  - CPU write to CNT in the same cycle as a match: write wins, PEND is not set that cycle.
  - W1C of PEND in the same cycle as a new match: set wins, PEND stays 1.
  - Write to CMP takes effect for the comparison in the following cycle.
- Clearing EN freezes CNT and PEND holds its value.
- Async reset asserted mid-operation clears all registers immediately; an in-flight write is dropped.

Optional Feature:
- Macro: TIMER_PRESCALE_EN.
- Defined:
  - Adds 8-bit PRE register at index 4, reset 0.
  - Internal 8-bit prescale counter counts 0..PRE while EN = 1, then produces a one-cycle tick and returns to 0.
  - CNT advances and matches are checked only on ticks; PRE = 0 means a tick every cycle.
  - Writing PRE resets the prescale counter.
  - Prescale counter clears when EN = 0.
- Undefined: index 4 reads 0 and ignores writes; CNT ticks every enabled cycle.

Test Plan:
- RAM byte write/read: write 32'h11223344 sel 4'b1111 to 0x100, then sel 4'b0100 data 32'h00AA0000 -> read 0x100 returns 32'h11AA3344; read with ce_i = 0 returns 0.
- Wrap/alias: with RAM_AW = 12, write 0xDEADBEEF to 0x0000_4000 -> read 0x0000_0000 returns 0xDEADBEEF.
- Timer match: CMP = 5, CTRL = 3'b011 -> PEND set on the edge where CNT = 5; timer_irq_o = 1 one cycle later; CNT keeps counting to 6, 7...
- Auto-clear and W1C: CTRL = 3'b111, CMP = 3 -> CNT sequence 0,1,2,3,0,1...; writing STAT = 1 clears the irq the next cycle unless it coincides with a match, in which case it stays 1.
- Collision: write CNT = 100 on the exact match cycle -> PEND stays 0, CNT reads 100 next cycle.
- TIMER_PRESCALE_EN: PRE = 3, EN = 1 -> CNT increments once every 4 cycles; async rst pulse mid-count -> CNT = 0, PRE = 0, irq = 0 immediately.
